// File: rtl/arrow_lane_manager.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : arrow_lane_manager                                       |
// | Description : Tracks scrolling rhythm-game arrows in a fixed pool of   |
// |               slots: spawns, per-frame scrolling, press judgement      |
// |               (GOOD/BAD/MISS) and saturating score.                    |
// | Options     : ARROW_COMBO_EN adds combo / max_combo outputs.           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module arrow_lane_manager #(
  parameter int LANES       = 4,
  parameter int SLOTS       = 10,
  parameter int SPAWN_Y     = 480,
  parameter int TARGET_Y    = 40,
  parameter int HIT_WINDOW  = 16,
  parameter int SCROLL_STEP = 1
) (
  input  logic                  arrowClk,
  input  logic                  reset_n,
  input  logic                  frame_tick,
  input  logic                  shiftUp,
  input  logic [LANES-1:0]      stripArrows,
  input  logic [LANES-1:0]      press,
  output logic [SLOTS-1:0]      slot_valid,
  output logic [SLOTS*10-1:0]   slot_y,
  output logic [SLOTS*4-1:0]    spriteID,
  output logic                  judge_valid,
  output logic [1:0]            judge_code,
  output logic [15:0]           score,
  output logic                  overflow
`ifdef ARROW_COMBO_EN
  ,
  output logic [7:0]            combo,
  output logic [7:0]            max_combo
`endif
);

  localparam logic [1:0] C_GOOD = 2'd0;
  localparam logic [1:0] C_BAD  = 2'd1;
  localparam logic [1:0] C_MISS = 2'd2;

  // Per-slot state
  logic [SLOTS-1:0] valid_q, valid_d;
  logic [2:0]       lane_q [SLOTS];
  logic [2:0]       lane_d [SLOTS];
  logic [9:0]       y_q    [SLOTS];
  logic [9:0]       y_d    [SLOTS];

  // Judgement / score state
  logic             judge_valid_q;
  logic [1:0]       judge_code_q, judge_code_d;
  logic [15:0]      score_q, score_d;
  logic             overflow_q;

  // Combinational helpers
  logic [SLOTS-1:0] w_in_win;
  logic [SLOTS-1:0] w_hit;
  logic [3:0]       w_good_cnt;
  logic             w_bad;
  logic             w_miss;
  logic             w_found;
  logic             w_taken;
  logic [4:0]       w_free;
  logic [4:0]       w_pop;
  logic             w_spawn_ok;
  logic             w_ovf;
  logic [LANES-1:0] w_remain;
  logic [16:0]      w_score_sum;

  function automatic logic [3:0] sprite_of(input logic [2:0] ln);
    case (ln)
      3'd0:    sprite_of = 4'h6;
      3'd1:    sprite_of = 4'h4;
      3'd2:    sprite_of = 4'h5;
      3'd3:    sprite_of = 4'h7;
      default: sprite_of = {1'b0, ln};
    endcase
  endfunction

  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    assign w_in_win[s] = (y_q[s] >= 10'(TARGET_Y))
                       ? ((y_q[s] - 10'(TARGET_Y)) <= 10'(HIT_WINDOW))
                       : ((10'(TARGET_Y) - y_q[s]) <= 10'(HIT_WINDOW));
    assign slot_valid[s]        = valid_q[s];
    assign slot_y[s*10 +: 10]   = valid_q[s] ? y_q[s] : 10'd0;
    assign spriteID[s*4 +: 4]   = valid_q[s] ? sprite_of(lane_q[s]) : 4'hF;
  end

  // Per pressed lane, claim the lowest in-window slot of that lane (pre-step y)
  always_comb begin
    w_hit      = '0;
    w_good_cnt = 4'd0;
    w_bad      = 1'b0;
    w_found    = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      w_found = 1'b0;
      if (press[l]) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (!w_found && valid_q[s] && (lane_q[s] == 3'(l)) && w_in_win[s]) begin
            w_found  = 1'b1;
            w_hit[s] = 1'b1;
          end
        end
        if (w_found) w_good_cnt = w_good_cnt + 4'd1;
        else         w_bad      = 1'b1;
      end
    end
  end

  // Free slots are counted from the current state so freed slots wait a cycle
  always_comb begin
    w_free = 5'd0;
    w_pop  = 5'd0;
    for (int s = 0; s < SLOTS; s++) w_free = w_free + {4'd0, ~valid_q[s]};
    for (int l = 0; l < LANES; l++) w_pop  = w_pop  + {4'd0, stripArrows[l]};
    w_spawn_ok = shiftUp && (w_pop != 5'd0) && (w_pop <= w_free);
    w_ovf      = shiftUp && (w_pop > w_free);
  end

  // Slot next state: hit, scroll/retire, or spawn into an empty slot
  always_comb begin
    valid_d  = valid_q;
    lane_d   = lane_q;
    y_d      = y_q;
    w_miss   = 1'b0;
    w_taken  = 1'b0;
    w_remain = stripArrows;
    for (int s = 0; s < SLOTS; s++) begin
      w_taken = 1'b0;
      if (valid_q[s]) begin
        if (w_hit[s]) begin
          valid_d[s] = 1'b0;
          y_d[s]     = 10'd0;
        end else if (frame_tick) begin
          if (y_q[s] < 10'(SCROLL_STEP)) begin
            valid_d[s] = 1'b0;
            y_d[s]     = 10'd0;
            w_miss     = 1'b1;
          end else begin
            y_d[s] = y_q[s] - 10'(SCROLL_STEP);
          end
        end
      end else if (w_spawn_ok) begin
        for (int l = 0; l < LANES; l++) begin
          if (!w_taken && w_remain[l]) begin
            w_taken     = 1'b1;
            w_remain[l] = 1'b0;
            valid_d[s]  = 1'b1;
            lane_d[s]   = 3'(l);
            y_d[s]      = 10'(SPAWN_Y);
          end
        end
      end
    end
  end

  // Judgement code priority GOOD > BAD > MISS; score saturates
  always_comb begin
    judge_code_d = judge_code_q;
    if (w_good_cnt != 4'd0) judge_code_d = C_GOOD;
    else if (w_bad)         judge_code_d = C_BAD;
    else if (w_miss)        judge_code_d = C_MISS;
    w_score_sum = {1'b0, score_q} + {13'd0, w_good_cnt};
    score_d     = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge arrowClk) begin
    if (!reset_n) begin
      valid_q       <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        lane_q[s] <= 3'd0;
        y_q[s]    <= 10'd0;
      end
      judge_valid_q <= 1'b0;
      judge_code_q  <= C_GOOD;
      score_q       <= 16'd0;
      overflow_q    <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      lane_q        <= lane_d;
      y_q           <= y_d;
      judge_valid_q <= (w_good_cnt != 4'd0) || w_bad || w_miss;
      judge_code_q  <= judge_code_d;
      score_q       <= score_d;
      overflow_q    <= overflow_q | w_ovf;
    end
  end

  assign judge_valid = judge_valid_q;
  assign judge_code  = judge_code_q;
  assign score       = score_q;
  assign overflow    = overflow_q;

`ifdef ARROW_COMBO_EN
  logic [7:0] combo_q, combo_d;
  logic [7:0] max_combo_q, max_combo_d;
  logic [8:0] w_combo_sum;

  // Combo breaks on any BAD or MISS, otherwise grows by the GOOD count
  always_comb begin
    w_combo_sum = {1'b0, combo_q} + {5'd0, w_good_cnt};
    if (w_bad || w_miss) combo_d = 8'd0;
    else                 combo_d = w_combo_sum[8] ? 8'hFF : w_combo_sum[7:0];
    max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
  end

  // Combo registers
  always_ff @(posedge arrowClk) begin
    if (!reset_n) begin
      combo_q     <= 8'd0;
      max_combo_q <= 8'd0;
    end else begin
      combo_q     <= combo_d;
      max_combo_q <= max_combo_d;
    end
  end

  assign combo     = combo_q;
  assign max_combo = max_combo_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arrow_lane_manager.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_arrow_lane_manager                                    |
// | Description : Directed self-checking bench for arrow_lane_manager      |
// |               (default parameters). Combo checks under ARROW_COMBO_EN. |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_arrow_lane_manager;

  logic         arrowClk = 1'b0;
  logic         reset_n  = 1'b0;
  logic         frame_tick = 1'b0;
  logic         shiftUp = 1'b0;
  logic [3:0]   stripArrows = 4'd0;
  logic [3:0]   press = 4'd0;
  logic [9:0]   slot_valid;
  logic [99:0]  slot_y;
  logic [39:0]  spriteID;
  logic         judge_valid;
  logic [1:0]   judge_code;
  logic [15:0]  score;
  logic         overflow;
`ifdef ARROW_COMBO_EN
  logic [7:0]   combo;
  logic [7:0]   max_combo;
`endif

  int checks = 0;
  int errors = 0;

  arrow_lane_manager dut (
    .arrowClk    (arrowClk),
    .reset_n     (reset_n),
    .frame_tick  (frame_tick),
    .shiftUp     (shiftUp),
    .stripArrows (stripArrows),
    .press       (press),
    .slot_valid  (slot_valid),
    .slot_y      (slot_y),
    .spriteID    (spriteID),
    .judge_valid (judge_valid),
    .judge_code  (judge_code),
    .score       (score),
    .overflow    (overflow)
`ifdef ARROW_COMBO_EN
    ,
    .combo       (combo),
    .max_combo   (max_combo)
`endif
  );

  always #5 arrowClk = ~arrowClk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; pulses are cleared and outputs are
  // sampled 1 time unit after the rising edge.
  task automatic pulse(input logic ft, input logic su, input logic [3:0] sa, input logic [3:0] pr);
    frame_tick = ft; shiftUp = su; stripArrows = sa; press = pr;
    @(posedge arrowClk); #1;
    frame_tick = 1'b0; shiftUp = 1'b0; stripArrows = 4'd0; press = 4'd0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pulse(1'b1, 1'b1, 4'b1111, 4'b1111);
    pulse(1'b1, 1'b1, 4'b1111, 4'b1111);
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset wins over coincident spawn/press/tick
    do_reset();
    chk("rst_valid",  slot_valid, 0);
    chk("rst_y",      slot_y, 0);
    chk("rst_sprite", spriteID, 40'hFFFFFFFFFF);
    chk("rst_jv",     judge_valid, 0);
    chk("rst_jc",     judge_code, 0);
    chk("rst_score",  score, 0);
    chk("rst_ovf",    overflow, 0);

    // Spawn lanes 0 and 3
    pulse(1'b0, 1'b1, 4'b1001, 4'd0);
    chk("spawn_valid",  slot_valid, 10'b0000000011);
    chk("spawn_y",      slot_y, (128'd480 << 10) | 128'd480);
    chk("spawn_sprite", spriteID, 40'hFFFFFFFF76);

    // Single lane-0 arrow scrolled to the judgement line and hit
    do_reset();
    pulse(1'b0, 1'b1, 4'b0001, 4'd0);
    ticks(440);
    chk("scroll_y40",   slot_y[9:0], 40);
    chk("scroll_nojv",  judge_valid, 0);
    pulse(1'b0, 1'b0, 4'd0, 4'b0001);
    chk("hit_jv",    judge_valid, 1);
    chk("hit_jc",    judge_code, 0);
    chk("hit_score", score, 1);
    chk("hit_clear", slot_valid, 0);

    // Window edge: 17 rows off is BAD, 16 rows off is GOOD
    pulse(1'b0, 1'b1, 4'b0100, 4'd0);
    chk("lane2_sprite", spriteID[3:0], 4'h5);
    ticks(423);
    chk("edge_y57", slot_y[9:0], 57);
    pulse(1'b0, 1'b0, 4'd0, 4'b0100);
    chk("edge57_jv",    judge_valid, 1);
    chk("edge57_jc",    judge_code, 1);
    chk("edge57_keep",  slot_valid, 10'b1);
    chk("edge57_score", score, 1);
    ticks(1);
    chk("edge_jv_low", judge_valid, 0);
    pulse(1'b0, 1'b0, 4'd0, 4'b0100);
    chk("edge56_jc",    judge_code, 0);
    chk("edge56_score", score, 2);
    chk("edge56_clear", slot_valid, 0);

    // Retire: y reaches 0 after 480 ticks, retires on the next tick
    pulse(1'b0, 1'b1, 4'b0010, 4'd0);
    ticks(480);
    chk("miss_y0",    slot_y[9:0], 0);
    chk("miss_still", slot_valid, 10'b1);
    chk("miss_nojv",  judge_valid, 0);
    ticks(1);
    chk("miss_gone", slot_valid, 0);
    chk("miss_jv",   judge_valid, 1);
    chk("miss_jc",   judge_code, 2);
    pulse(1'b0, 1'b0, 4'd0, 4'd0);
    chk("miss_jv_low", judge_valid, 0);
    chk("miss_jc_hold", judge_code, 2);
    pulse(1'b0, 1'b0, 4'd0, 4'b0010);
    chk("late_jc",    judge_code, 1);
    chk("late_jv",    judge_valid, 1);
    chk("late_score", score, 2);

    // Fill all ten slots, then overflow; empty spawn request is a no-op
    pulse(1'b0, 1'b1, 4'b1111, 4'd0);
    pulse(1'b0, 1'b1, 4'b1111, 4'd0);
    pulse(1'b0, 1'b1, 4'b0011, 4'd0);
    chk("full_valid",  slot_valid, 10'h3FF);
    chk("full_ovf0",   overflow, 0);
    chk("full_sprite", spriteID, 40'h4675467546);
    pulse(1'b0, 1'b1, 4'b0011, 4'd0);
    chk("ovf_set",   overflow, 1);
    chk("ovf_valid", slot_valid, 10'h3FF);
    pulse(1'b0, 1'b1, 4'b0000, 4'd0);
    chk("zero_valid", slot_valid, 10'h3FF);
    chk("zero_ovf",   overflow, 1);

    // Mid-game reset discards everything, no pulse
    do_reset();
    chk("mid_rst_valid", slot_valid, 0);
    chk("mid_rst_jv",    judge_valid, 0);
    chk("mid_rst_ovf",   overflow, 0);
    chk("mid_rst_score", score, 0);

    // Lanes 0,1 at y=40 hit while slot 0 retires and a spawn finds no free slot
    pulse(1'b0, 1'b1, 4'b0100, 4'd0);     // slot0 lane2
    ticks(40);                            // slot0 y=440
    pulse(1'b0, 1'b1, 4'b0011, 4'd0);     // slot1 lane0, slot2 lane1
    ticks(440);                           // slot0 y=0, slots1,2 y=40
    pulse(1'b0, 1'b1, 4'b1111, 4'd0);     // slots 3..6
    pulse(1'b0, 1'b1, 4'b0111, 4'd0);     // slots 7..9
    chk("multi_full", slot_valid, 10'h3FF);
    chk("multi_y40",  slot_y[29:10], (20'd40 << 10) | 20'd40);
    pulse(1'b1, 1'b1, 4'b0100, 4'b0011);
    chk("multi_jv",    judge_valid, 1);
    chk("multi_jc",    judge_code, 0);
    chk("multi_score", score, 2);
    chk("multi_valid", slot_valid, 10'b1111111000);
    chk("multi_ovf",   overflow, 1);
    chk("multi_step",  slot_y[39:30], 479);

    // Spawn coincident with a tick keeps SPAWN_Y; retired slot gave no late MISS
    pulse(1'b1, 1'b1, 4'b0100, 4'd0);
    chk("co_nomiss", judge_valid, 0);
    chk("co_jc",     judge_code, 0);
    chk("co_valid",  slot_valid, 10'b1111111001);
    chk("co_y_new",  slot_y[9:0], 480);
    chk("co_y_old",  slot_y[39:30], 478);
    chk("co_sprite", spriteID[3:0], 4'h5);

`ifdef ARROW_COMBO_EN
    // Combo: GOOD, GOOD, BAD, GOOD
    do_reset();
    chk("cmb_rst", combo, 0);
    pulse(1'b0, 1'b1, 4'b0111, 4'd0);
    ticks(440);
    pulse(1'b0, 1'b0, 4'd0, 4'b0001);
    chk("cmb_1", combo, 1);
    pulse(1'b0, 1'b0, 4'd0, 4'b0010);
    chk("cmb_2", combo, 2);
    pulse(1'b0, 1'b0, 4'd0, 4'b0001);
    chk("cmb_bad", combo, 0);
    pulse(1'b0, 1'b0, 4'd0, 4'b0100);
    chk("cmb_3",   combo, 1);
    chk("cmb_max", max_combo, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arrow_lane_manager.md
ARROW_LANE_MANAGER -- requirements
Module: arrow_lane_manager

Interface
REQ-001 Parameter LANES, default 4, number of arrow lanes (1..8).
REQ-002 Parameter SLOTS, default 10, number of on-screen arrow slots (2..16).
REQ-003 Parameter SPAWN_Y, default 480, row where new arrows enter.
REQ-004 Parameter TARGET_Y, default 40, row of the judgement line.
REQ-005 Parameter HIT_WINDOW, default 16, max |y - TARGET_Y| counted as GOOD.
REQ-006 Parameter SCROLL_STEP, default 1, rows moved per frame tick (1..15).
REQ-007 arrowClk  input  1  sole clock; all state changes on rising edge.
REQ-008 reset_n  input  1  reset; synchronous, active-low.
REQ-009 frame_tick  input  1  one-cycle pulse per video frame; advances all arrows.
REQ-010 shiftUp  input  1  spawn request; stripArrows sampled this cycle.
REQ-011 stripArrows  input  LANES  bit l set = spawn arrow in lane l.
REQ-012 press  input  LANES  one-cycle per-lane button pulses.
REQ-013 slot_valid  output  SLOTS  slot occupied.
REQ-014 slot_y  output  SLOTS*10  packed 10-bit row per slot, slot 0 in LSBs.
REQ-015 spriteID  output  SLOTS*4  packed sprite code per slot.
REQ-016 judge_valid  output  1  one-cycle judgement pulse.
REQ-017 judge_code  output  2  0 GOOD, 1 BAD, 2 MISS; held between pulses.
REQ-018 score  output  16  count of GOOD judgements, saturating at 16'hFFFF.
REQ-019 overflow  output  1  sticky: a spawn was dropped.

Function
REQ-020 State per slot: valid, lane index, 10-bit y; all registered.
REQ-021 frame_tick: every valid slot with y >= SCROLL_STEP SHALL get y - SCROLL_STEP next cycle.
REQ-022 frame_tick, valid slot with y < SCROLL_STEP SHALL be cleared (retire) and counted as a MISS.
REQ-023 shiftUp: if free slots >= popcount(stripArrows), each set lane SHALL occupy one free slot, lanes ascending into ascending free slot indices, y = SPAWN_Y.
REQ-024 shiftUp with insufficient free slots SHALL spawn nothing and set overflow.
REQ-025 shiftUp with stripArrows == 0 SHALL change no state.
REQ-026 Slots freed by retire or hit in a cycle SHALL NOT be reused by a spawn in that same cycle.
REQ-027 Arrows spawned with a coincident frame_tick SHALL hold y = SPAWN_Y (not stepped).
REQ-028 press[l]: lowest-index valid slot in lane l with |y - TARGET_Y| <= HIT_WINDOW SHALL be cleared and GOOD produced; no such slot -> BAD, no slot change.
REQ-029 Hit check SHALL use pre-step y when press and frame_tick coincide; a hit slot SHALL NOT also retire.
REQ-030 Several events in one cycle: judge_code priority GOOD > BAD > MISS, single judge_valid pulse; score adds number of GOOD lanes that cycle, saturating.
REQ-031 Judgement outputs SHALL be registered: one-cycle latency from press/frame_tick.
REQ-032 spriteID for valid slot: lane 0 -> 4'h6, 1 -> 4'h4, 2 -> 4'h5, 3 -> 4'h7, lane >= 4 -> lane number; invalid slot -> 4'hF.
REQ-033 slot_y of invalid slot SHALL read 0.

Reset
REQ-034 reset_n low at a rising edge SHALL clear all slot_valid, slot_y to 0, spriteID to 4'hF, judge_valid 0, judge_code 0, score 0, overflow 0, combo state 0.
REQ-035 Reset SHALL take priority over any coincident shiftUp, press or frame_tick.
REQ-036 Reset asserted mid-game SHALL discard all in-flight arrows; no judgement pulse generated.

Configuration
REQ-037 Macro ARROW_COMBO_EN defined: add outputs combo (8 bits) and max_combo (8 bits); combo +1 per GOOD (saturate 255), 0 on BAD or MISS; max_combo tracks peak.
REQ-038 Macro ARROW_COMBO_EN undefined: combo and max_combo ports and logic absent; all other behaviour identical.

Verification
REQ-039 Reset, shiftUp with stripArrows=4'b1001 -> slots 0,1 valid, lanes 0,3, y=480, spriteID 6 and 7; others 4'hF.
REQ-040 One arrow, 440 frame_ticks, press lane 0 -> y=40, GOOD, score=1, slot cleared next cycle.
REQ-041 One arrow, 480 frame_ticks, no press -> slot retired, judge_code=2 pulse; press afterwards -> BAD, score unchanged.
REQ-042 Fill 10 slots, shiftUp 4'b0011 -> no spawn, overflow=1, occupancy unchanged.
REQ-043 Lanes 0 and 1 both at y=40, press=4'b0011 plus frame_tick retiring another slot -> one pulse, code GOOD, score +2, no MISS pulse.
REQ-044 ARROW_COMBO_EN: GOOD, GOOD, BAD, GOOD -> combo 1,2,0,1; max_combo 2.
